// File: rtl/ceas_pkg.sv
// Shared types and limits for the clock/alarm core.
package ceas_pkg;

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam int MAX_ORE = 23;
  localparam int MAX_MIN = 59;
  localparam int MAX_SEC = 59;
  localparam int W_ORE   = 5;
  localparam int W_MIN   = 6;

  // 24h hour to 12h dial value: 0 -> 12, 13..23 -> 1..11.
  function automatic logic [3:0] to_ore12(input logic [W_ORE-1:0] h);
    if (h == '0)
      return 4'd12;
    else if (h > 5'd12)
      return 4'(h - 5'd12);
    else
      return h[3:0];
  endfunction

endpackage

// File: rtl/divizor_1hz.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; clr restarts the second.
module divizor_1hz #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || clr)
      r_cnt <= '0;
    else if (r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + W'(1);
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/ceas_alarma_core.sv
// Running hh:mm:ss clock, alarm registers and ring/snooze FSM.
// Optional 12-hour outputs (ore12, pm) built when CEAS_FORMAT12_EN is defined.
module ceas_alarma_core
  import ceas_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_timp,
  input  logic             load_alarma,
  input  logic [W_ORE-1:0] ore_in,
  input  logic [W_MIN-1:0] minute_in,
  input  logic             alarm_en,
  input  logic             btn_snooze,
  input  logic             btn_off,
  output logic [W_ORE-1:0] ore,
  output logic [W_MIN-1:0] minute,
  output logic [W_MIN-1:0] secunde,
  output logic [W_ORE-1:0] ora_alarma,
  output logic [W_MIN-1:0] minut_alarma,
  output logic             suna,
  output logic             amanat,
  output logic             tick_1hz
`ifdef CEAS_FORMAT12_EN
  ,
  output logic [3:0]       ore12,
  output logic             pm
`endif
);

  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int W_RING = $clog2(RING_SEC + 1);
  localparam int W_SNZ  = $clog2(SNOOZE_TICKS + 1);
  localparam logic [W_RING-1:0] RING_LAST = W_RING'(RING_SEC - 1);
  localparam logic [W_SNZ-1:0]  SNZ_LOAD  = W_SNZ'(SNOOZE_TICKS);

  logic             w_tick, w_tick_eff, w_load_t, w_load_a, w_match;
  logic             w_snooze_edge, w_off_edge;
  logic [W_ORE-1:0] w_ore_n;
  logic [W_MIN-1:0] w_min_n, w_sec_n;

  state_t              r_state;
  logic [W_RING-1:0]   r_ring_cnt;
  logic [W_SNZ-1:0]    r_snooze_cnt;
  logic                r_tick_d, r_snooze_q, r_off_q;

  // Out-of-range values make the whole load a no-op, prescaler included.
  assign w_load_t = load_timp && (ore_in <= W_ORE'(MAX_ORE)) && (minute_in <= W_MIN'(MAX_MIN));
  assign w_load_a = load_alarma && (ore_in <= W_ORE'(MAX_ORE)) && (minute_in <= W_MIN'(MAX_MIN));

  divizor_1hz #(.TICK_DIV(TICK_DIV)) u_div (
    .clock (clock),
    .reset (reset),
    .clr   (w_load_t),
    .tick  (w_tick)
  );

  assign tick_1hz   = w_tick;
  assign w_tick_eff = w_tick && !w_load_t;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_ore_n = ore;
    w_min_n = minute;
    w_sec_n = secunde;
    if (w_load_t) begin
      w_ore_n = ore_in;
      w_min_n = minute_in;
      w_sec_n = '0;
    end else if (w_tick) begin
      if (secunde == W_MIN'(MAX_SEC)) begin
        w_sec_n = '0;
        if (minute == W_MIN'(MAX_MIN)) begin
          w_min_n = '0;
          w_ore_n = (ore == W_ORE'(MAX_ORE)) ? '0 : ore + W_ORE'(1);
        end else begin
          w_min_n = minute + W_MIN'(1);
        end
      end else begin
        w_sec_n = secunde + W_MIN'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ore      <= '0;
      minute   <= '0;
      secunde  <= '0;
      r_tick_d <= 1'b0;
`ifdef CEAS_FORMAT12_EN
      ore12    <= 4'd12;
      pm       <= 1'b0;
`endif
    end else begin
      ore      <= w_ore_n;
      minute   <= w_min_n;
      secunde  <= w_sec_n;
      r_tick_d <= w_tick_eff;
`ifdef CEAS_FORMAT12_EN
      ore12    <= to_ore12(w_ore_n);
      pm       <= (w_ore_n >= W_ORE'(12));
`else
      // 12-hour view not built.
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ora_alarma   <= '0;
      minut_alarma <= '0;
    end else if (w_load_a) begin
      ora_alarma   <= ore_in;
      minut_alarma <= minute_in;
    end
  end

  assign w_match = r_tick_d && alarm_en && (secunde == '0) &&
                   (ore == ora_alarma) && (minute == minut_alarma);
  assign w_snooze_edge = btn_snooze && !r_snooze_q;
  assign w_off_edge    = btn_off && !r_off_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ring_cnt   <= '0;
      r_snooze_cnt <= '0;
      r_snooze_q   <= 1'b0;
      r_off_q      <= 1'b0;
      suna         <= 1'b0;
      amanat       <= 1'b0;
    end else begin
      r_snooze_q <= btn_snooze;
      r_off_q    <= btn_off;
      if (load_alarma || !alarm_en) begin
        r_state <= IDLE;
        suna    <= 1'b0;
        amanat  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (w_match) begin
            r_state    <= RING;
            r_ring_cnt <= '0;
            suna       <= 1'b1;
          end
          RING: if (w_off_edge) begin
            r_state <= IDLE;
            suna    <= 1'b0;
          end else if (w_snooze_edge) begin
            r_state      <= SNOOZE;
            r_snooze_cnt <= SNZ_LOAD;
            suna         <= 1'b0;
            amanat       <= 1'b1;
          end else if (w_tick_eff) begin
            if (r_ring_cnt == RING_LAST) begin
              r_state <= IDLE;
              suna    <= 1'b0;
            end else begin
              r_ring_cnt <= r_ring_cnt + W_RING'(1);
            end
          end
          SNOOZE: if (w_off_edge) begin
            r_state <= IDLE;
            amanat  <= 1'b0;
          end else if (w_tick_eff) begin
            if (r_snooze_cnt == W_SNZ'(1)) begin
              r_state    <= RING;
              r_ring_cnt <= '0;
              suna       <= 1'b1;
              amanat     <= 1'b0;
            end else begin
              r_snooze_cnt <= r_snooze_cnt - W_SNZ'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            suna    <= 1'b0;
            amanat  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ceas_alarma_core.md
Name: ceas_alarma_core

Overview:
- Timekeeping and alarm core; sits directly downstream of the hour/minute setting stage.
- Consumes that stage's one-cycle load_timp/load_alarma strobes and its ore_in/minute_in values.
- Keeps running time as hh:mm:ss, holds the alarm time, and runs the ring/snooze state machine whose outputs drive the display and buzzer.

Parameters:
- TICK_DIV, 50000000, system clocks per 1 s tick (bench uses 4).
- RING_SEC, 60, seconds of ringing before auto-off.
- SNOOZE_MIN, 5, snooze length in minutes.

Ports:
- clock  in  1  system clock; all logic on posedge (upstream setter updates on negedge, giving half-cycle margin).
- reset  in  1  reset, synchronous, active-high.
- load_timp  in  1  one-cycle strobe: load running time from ore_in/minute_in.
- load_alarma  in  1  one-cycle strobe: load alarm time from ore_in/minute_in.
- ore_in  in  5  hours to load, 0..23.
- minute_in  in  6  minutes to load, 0..59.
- alarm_en  in  1  alarm armed (level).
- btn_snooze  in  1  snooze button (level, internally edge-detected).
- btn_off  in  1  alarm off button (level, internally edge-detected).
- ore  out  5  current hours.
- minute  out  6  current minutes.
- secunde  out  6  current seconds.
- ora_alarma  out  5  stored alarm hours.
- minut_alarma  out  6  stored alarm minutes.
- suna  out  1  high while state is RING (buzzer).
- amanat  out  1  high while state is SNOOZE.
- tick_1hz  out  1  one-cycle pulse per second.

Behaviour:
- Reset values:
  - All outputs 0.
  - Prescaler 0, FSM state IDLE.
  - Button edge registers 0, ring and snooze counters 0.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick_1hz is high in the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
- Time counter, advanced on tick:
  - secunde 59->0 carries to minute.
  - minute 59->0 carries to ore.
  - ore 23->0.
  - Width is exact; no overflow beyond these limits.
- load_timp:
  - Next cycle: ore=ore_in, minute=minute_in, secunde=0, prescaler=0.
  - Has priority over a tick in the same cycle; that tick is lost.
  - If ore_in>23 or minute_in>59, the whole load is ignored.
- load_alarma:
  - Next cycle: ora_alarma/minut_alarma updated, with the same range check.
  - FSM forced to IDLE.
  - Independent of the time counter; both strobes in one cycle both take effect.
- Match condition:
  - tick_d (tick delayed one cycle) && alarm_en && secunde==0 && ore==ora_alarma && minute==minut_alarma.
  - A load_timp that lands exactly on the alarm time does not trigger, because tick_d is 0.
- Buttons:
  - Rising edge = current high && previous-cycle low.
  - A held button acts once.
- FSM transitions:
  - IDLE -> RING on match; ring_cnt=0.
  - RING:
    - off edge -> IDLE.
    - Else snooze edge -> SNOOZE with snooze_cnt=SNOOZE_MIN*60.
    - Else on tick, ring_cnt++; when ring_cnt reaches RING_SEC-1 on a tick -> IDLE.
  - SNOOZE:
    - off edge -> IDLE.
    - Else on tick snooze_cnt--; on the tick where snooze_cnt==1 -> RING with ring_cnt=0.
  - Any state -> IDLE when alarm_en==0 or load_alarma.
  - Priority, highest first: reset, load_alarma, alarm_en low, off, snooze, tick.
- A match while in RING or SNOOZE is ignored.
- Reset mid-ring returns every output to its reset value in the next cycle.

Optional Feature:
- Macro CEAS_FORMAT12_EN.
- Defined:
  - Adds outputs ore12 [3:0] (1..12; 0h->12, 13..23->1..11) and pm (ore>=12).
  - Both are registered and updated in the same cycle as ore; reset values are ore12=12, pm=0.
- Undefined: the ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ceas_pkg:
  - FSM state enum {IDLE, RING, SNOOZE}.
  - Constants MAX_ORE=23, MAX_MIN=59, MAX_SEC=59.
  - Width constants W_ORE=5, W_MIN=6.
- One sub-module, divizor_1hz:
  - Parameter TICK_DIV.
  - Inputs clock, reset, clr (driven by load_timp).
  - Output tick.
- Time counter, alarm registers and FSM stay in ceas_alarma_core.

Test Plan:
- Reset then 60 ticks (TICK_DIV=4) -> secunde 0..59 then 0, minute=1, tick_1hz every 4 cycles.
- load_timp with ore_in=23, minute_in=59, then 60 ticks -> 00:00:00; load_timp with ore_in=24 -> time unchanged.
- Alarm 07:00, alarm_en=1, time loaded 06:59:00, run 60 ticks -> suna rises the cycle after the tick to 07:00:00; RING_SEC ticks later -> IDLE, suna=0.
- In RING, pulse btn_snooze -> amanat=1, suna=0; after SNOOZE_MIN*60 ticks -> suna=1 again. Holding btn_snooze high for 10 cycles snoozes only once.
- In RING, btn_off and btn_snooze rise in the same cycle -> IDLE (off wins). alarm_en dropped while in SNOOZE -> IDLE next cycle.
- load_timp and tick in the same cycle -> loaded value with secunde=0. With CEAS_FORMAT12_EN, ore=13 -> ore12=1, pm=1; ore=0 -> ore12=12, pm=0.
